// File: rtl/cam_sccb_config_if.sv
// Bus bundle between the camera configuration sequencer and the top level:
// start/status handshake, registered-ROM table port and the SCCB lines.
interface cam_sccb_config_if #(
   parameter int TAW = 8
);
   logic           start;
   logic [TAW-1:0] rom_addr;
   logic [15:0]    rom_data;
   logic           sccb_scl;
   logic           sccb_sda_o;
   logic           sccb_sda_oe;
   logic           busy;
   logic           done;

   modport master (
      input  start, rom_data,
      output rom_addr, sccb_scl, sccb_sda_o, sccb_sda_oe, busy, done
   );

   modport slave (
      output start, rom_data,
      input  rom_addr, sccb_scl, sccb_sda_o, sccb_sda_oe, busy, done
   );
endinterface

// File: rtl/cam_sccb_config.sv
// OV7670 configuration sequencer: walks a {reg, data} table and sends each
// entry as a 3-phase SCCB write; 16'hFFFF ends the table, 16'hFFF0 inserts a wait.
//
// state  | meaning
// IDLE   | lines released, waiting for start
// FETCH  | one cycle of registered-ROM latency
// DECODE | classify the table word (end / delay / write)
// START  | start condition, 4 quarters
// BITS   | 27 bit slots x 4 quarters, MSB first
// STOP   | stop condition, 4 quarters
// GAP    | 4 quarters of released bus between writes
// DELAY  | wait DELAY_CYCLES clocks with lines released
// NEXT   | advance the table address or finish at the entry limit
// FIN    | raise done, drop busy
module cam_sccb_config #(
   parameter int          CLK_DIV      = 63,
   parameter int          TAW          = 8,
   parameter int          MAX_ENTRIES  = 256,
   parameter int          DELAY_CYCLES = 250000,
   parameter logic [7:0]  DEV_ID       = 8'h42
) (
   input  logic                  clk,
   input  logic                  rst,
   cam_sccb_config_if.master     cfg
);
   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_DECODE = 4'd2;
   localparam logic [3:0] S_START  = 4'd3;
   localparam logic [3:0] S_BITS   = 4'd4;
   localparam logic [3:0] S_STOP   = 4'd5;
   localparam logic [3:0] S_GAP    = 4'd6;
   localparam logic [3:0] S_DELAY  = 4'd7;
   localparam logic [3:0] S_NEXT   = 4'd8;
   localparam logic [3:0] S_FIN    = 4'd9;

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DW = $clog2(DELAY_CYCLES + 1);

   logic [3:0]     r_state;
   logic [QW-1:0]  r_qcnt;
   logic [1:0]     r_q;
   logic [4:0]     r_bit;
   logic [26:0]    r_shift;
   logic [DW-1:0]  r_dcnt;
   logic [TAW-1:0] r_rom_addr;
   logic           r_scl;
   logic           r_sda;
   logic           r_oe;
   logic           r_busy;
   logic           r_done;

   logic           w_tick;
   logic           w_timed;
   logic           w_dc_slot;

   assign w_tick    = (r_qcnt == QW'(CLK_DIV - 1));
   assign w_timed   = (r_state == S_START) || (r_state == S_BITS) ||
                      (r_state == S_STOP)  || (r_state == S_GAP);
   // slots 9, 18 and 27 are the ACK/don't-care positions; bus is released there
   assign w_dc_slot = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);

   // quarter-period counter; held at zero outside the SCCB phases so START begins a fresh quarter
   always_ff @(posedge clk) begin
      if (!rst || !w_timed) begin
         r_qcnt <= '0;
      end else if (w_tick) begin
         r_qcnt <= '0;
      end else begin
         r_qcnt <= r_qcnt + QW'(1);
      end
   end

   // sequencer FSM; SCCB outputs are set at quarter boundaries for the quarter that follows
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_q        <= 2'd0;
         r_bit      <= 5'd0;
         r_shift    <= '0;
         r_dcnt     <= '0;
         r_rom_addr <= '0;
         r_scl      <= 1'b1;
         r_sda      <= 1'b1;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_scl <= 1'b1;
               r_sda <= 1'b1;
               r_oe  <= 1'b0;
               if (cfg.start) begin
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_rom_addr <= '0;
                  r_state    <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_DECODE;
            S_DECODE: begin
               if (cfg.rom_data == 16'hFFFF) begin
                  r_state <= S_FIN;
               end else if (cfg.rom_data == 16'hFFF0) begin
                  r_dcnt  <= DW'(DELAY_CYCLES - 1);
                  r_state <= S_DELAY;
               end else begin
                  r_shift <= {DEV_ID, 1'b1, cfg.rom_data[15:8], 1'b1, cfg.rom_data[7:0], 1'b1};
                  r_q     <= 2'd0;
                  r_bit   <= 5'd0;
                  r_scl   <= 1'b1;
                  r_sda   <= 1'b1;
                  r_oe    <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: if (w_tick) begin
               r_q <= r_q + 2'd1;
               if (r_q == 2'd1) r_sda <= 1'b0;
               if (r_q == 2'd3) begin
                  r_scl   <= 1'b0;
                  r_state <= S_BITS;
               end
            end
            S_BITS: if (w_tick) begin
               r_q <= r_q + 2'd1;
               case (r_q)
                  2'd0: begin
                     if (w_dc_slot) begin
                        r_oe  <= 1'b0;
                        r_sda <= 1'b1;
                     end else begin
                        r_oe  <= 1'b1;
                        r_sda <= r_shift[26];
                     end
                     r_shift <= {r_shift[25:0], 1'b0};
                  end
                  2'd1: r_scl <= 1'b1;
                  2'd3: begin
                     r_scl <= 1'b0;
                     if (r_bit == 5'd26) r_state <= S_STOP;
                     else                r_bit   <= r_bit + 5'd1;
                  end
                  default: ;
               endcase
            end
            S_STOP: if (w_tick) begin
               r_q <= r_q + 2'd1;
               case (r_q)
                  2'd0: begin
                     r_oe  <= 1'b1;
                     r_sda <= 1'b0;
                  end
                  2'd1: r_scl <= 1'b1;
                  2'd2: r_sda <= 1'b1;
                  default: begin
                     r_oe    <= 1'b0;
                     r_state <= S_GAP;
                  end
               endcase
            end
            S_GAP: if (w_tick) begin
               r_q <= r_q + 2'd1;
               if (r_q == 2'd3) r_state <= S_NEXT;
            end
            S_DELAY: begin
               if (r_dcnt == '0) r_state <= S_NEXT;
               else              r_dcnt  <= r_dcnt - DW'(1);
            end
            S_NEXT: begin
               if (r_rom_addr == TAW'(MAX_ENTRIES - 1)) begin
                  r_state <= S_FIN;
               end else begin
                  r_rom_addr <= r_rom_addr + TAW'(1);
                  r_state    <= S_FETCH;
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_scl   <= 1'b1;
               r_sda   <= 1'b1;
               r_oe    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cfg.rom_addr    = r_rom_addr;
   assign cfg.sccb_scl    = r_scl;
   assign cfg.sccb_sda_o  = r_sda;
   assign cfg.sccb_sda_oe = r_oe;
   assign cfg.busy        = r_busy;
   assign cfg.done        = r_done;
endmodule
